alu_bus_slave: RTL

ALU_BUS_SLAVE -- requirements
Module: alu_bus_slave

---
 rtl/alu_bus_slave.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_bus_slave.sv
// rtl/alu_bus_slave.sv - register-mapped ALU bus slave with issue/wait/done sequencing
// Define ALU_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module alu_bus_slave #(
    parameter int WORD_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           i_addr,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [WORD_BITS-1:0] i_writedata,
    output logic [WORD_BITS-1:0] o_readdata,
    output logic                 o_readdata_valid,
    output logic [WORD_BITS-1:0] o_operand_0_val,
    output logic [WORD_BITS-1:0] o_operand_1_val,
    output logic [WORD_BITS-1:0] o_type,
    output logic [WORD_BITS-1:0] o_op,
    output logic                 o_calc_start,
    input  logic [WORD_BITS-1:0] i_result_val,
    input  logic                 i_result_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state;
    logic [WORD_BITS-1:0] src0, src1, typ, op, result;
    logic [WORD_BITS-1:0] rd_mux;
    logic                 busy, done, timeout_err;
    logic                 wr_ctrl, start_req, clear_req;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign done      = (state == DONE);
    assign wr_ctrl   = i_write && (i_addr == 4'd4);
    assign start_req = wr_ctrl && i_writedata[0] && !busy;
    assign clear_req = wr_ctrl && i_writedata[1];

    assign o_operand_0_val = src0;
    assign o_operand_1_val = src1;
    assign o_type          = typ;
    assign o_op            = op;

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            4'd0:    rd_mux = src0;
            4'd1:    rd_mux = src1;
            4'd2:    rd_mux = typ;
            4'd3:    rd_mux = op;
            4'd5:    rd_mux = {{(WORD_BITS-3){1'b0}}, timeout_err, done, busy};
            4'd6:    rd_mux = result;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            src0             <= '0;
            src1             <= '0;
            typ              <= '0;
            op               <= '0;
            result           <= '0;
            o_readdata       <= '0;
            o_readdata_valid <= 1'b0;
            o_calc_start     <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            timeout_err      <= 1'b0;
            wait_cnt         <= '0;
`endif
        end else begin
            // Read mux samples pre-write register values, so read+write returns the old word
            o_readdata_valid <= i_read;
            o_readdata       <= i_read ? rd_mux : '0;
            o_calc_start     <= 1'b0;

            if (i_write && !busy) begin
                case (i_addr)
                    4'd0:    src0 <= i_writedata;
                    4'd1:    src1 <= i_writedata;
                    4'd2:    typ  <= i_writedata;
                    4'd3:    op   <= i_writedata;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        state        <= ISSUE;
                        o_calc_start <= 1'b1;
`ifdef ALU_TIMEOUT_EN
                        timeout_err  <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
`ifdef ALU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (i_result_valid) begin
                        result <= i_result_val;
                        state  <= DONE;
                    end else begin
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_result_valid) begin
                        result <= i_result_val;
                        state  <= DONE;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (start_req) begin
                        state        <= ISSUE;
                        o_calc_start <= 1'b1;
`ifdef ALU_TIMEOUT_EN
                        timeout_err  <= 1'b0;
`endif
                    end else if (clear_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
